hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of stall_count.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: insn_fd  input  32  instruction held in the F/D latch.
REQ-006 Port: insn_dx  input  32  instruction held in the D/X latch.
REQ-007 Port: branch_taken  input  1  X-stage redirect, valid this cycle.
REQ-008 Port: md_ready  input  1  multdiv result valid.
REQ-009 Port: pc_en, fd_en, dx_en, xm_en, mw_en  output  1 each  latch write enables.
REQ-010 Port: fd_flush, dx_flush, xm_flush  output  1 each  synchronous bubble insert (latch captures zero).
REQ-011 Port: md_start  output  1  one-cycle multdiv launch pulse.
REQ-012 Port: stall_count  output  CNT_W  cumulative front-end stall cycles.

Function
REQ-013 Decode fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
REQ-014 lw = opcode 01000; mul/div = opcode 00000 with aluop 00110/00111.
REQ-015 FD sources: rs and rt when FD opcode is 00000; rs otherwise; rd also when FD is sw (00111).
REQ-016 Load-use hazard: DX is lw, DX rd != 0, DX rd equals any FD source.
REQ-017 Load-use: pc_en=0, fd_en=0, dx_flush=1 for exactly that cycle; xm_en=mw_en=1.
REQ-018 FSM states: IDLE and MD_BUSY.
REQ-019 In IDLE, if DX holds mul/div: md_start=1 for that cycle only; next state MD_BUSY.
REQ-020 In the launch cycle and every MD_BUSY cycle without md_ready: pc_en=fd_en=dx_en=0, xm_flush=1, mw_en=1.
REQ-021 In MD_BUSY with md_ready=1: all enables=1, xm_flush=0; next state IDLE (XM captures the result in that cycle).
REQ-022 md_ready in IDLE SHALL be ignored.
REQ-023 md_start SHALL never assert in MD_BUSY.
REQ-024 branch_taken=1 (IDLE, no md_start): fd_flush=dx_flush=1, pc_en=1; overrides a load-use stall in the same cycle.
REQ-025 MD_BUSY or md_start overrides branch_taken and load-use; a mul/div in DX is never a branch.
REQ-026 No hazard: all enables=1, all flushes=0.
REQ-027 A stall cycle is any cycle with pc_en=0.
REQ-028 stall_count increments by one per stall cycle and wraps modulo 2^CNT_W.
REQ-029 All outputs except stall_count and FSM state SHALL be combinational from inputs and state.

Reset
REQ-030 reset=1 SHALL asynchronously force state=IDLE and stall_count=0.
REQ-031 While reset=1: all enables=1, all flushes=0, md_start=0.
REQ-032 Reset asserted in MD_BUSY SHALL abandon the operation; no md_start is reissued until a mul/div is seen in DX after release.

Configuration
REQ-033 Macro HAZARD_CTRL_STALL_CNT_EN defined: stall_count operates per REQ-028.
REQ-034 Macro HAZARD_CTRL_STALL_CNT_EN undefined: no counter register, stall_count tied to 0, all other behaviour identical.

Verification
REQ-035 DX=lw rd=5, FD=add rs=5 -> one cycle pc_en=fd_en=0, dx_flush=1, then all enables 1; stall_count 0->1.
REQ-036 DX=lw rd=0, FD=add rs=0 -> no stall, dx_flush=0.
REQ-037 DX=mul, md_ready after 4 cycles -> md_start high only in cycle 0; pc_en=0 and xm_flush=1 for cycles 0-3; cycle 4 all enables 1; stall_count=4.
REQ-038 branch_taken=1 with a load-use pair present -> fd_flush=dx_flush=1, pc_en=1, stall_count unchanged.
REQ-039 reset pulsed in MD_BUSY cycle 2 -> state IDLE immediately, stall_count=0, md_start=0; mul still in DX after release -> new md_start.
REQ-040 Build without HAZARD_CTRL_STALL_CNT_EN, rerun REQ-037 -> stall_count stays 0, all other outputs identical.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and multdiv busy stalls.
// Optional stall-cycle counter enabled by defining HAZARD_CTRL_STALL_CNT_EN.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      insn_fd,
  input  logic [31:0]      insn_dx,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_flush,
  output logic             md_start,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t r_state;
  state_t w_nextState;

  logic [4:0] w_fdOp, w_fdRd, w_fdRs, w_fdRt;
  logic [4:0] w_dxOp, w_dxRd, w_dxAluOp;
  logic       w_dxIsLw, w_dxIsMd, w_loadUse;

  assign w_fdOp    = insn_fd[31:27];
  assign w_fdRd    = insn_fd[26:22];
  assign w_fdRs    = insn_fd[21:17];
  assign w_fdRt    = insn_fd[16:12];
  assign w_dxOp    = insn_dx[31:27];
  assign w_dxRd    = insn_dx[26:22];
  assign w_dxAluOp = insn_dx[6:2];

  assign w_dxIsLw = (w_dxOp == OP_LW);
  assign w_dxIsMd = (w_dxOp == OP_RTYPE) &&
                    ((w_dxAluOp == ALU_MUL) || (w_dxAluOp == ALU_DIV));

  // A source register only matters if the FD instruction actually reads it.
  assign w_loadUse = w_dxIsLw && (w_dxRd != 5'd0) &&
                     ((w_dxRd == w_fdRs) ||
                      ((w_fdOp == OP_RTYPE) && (w_dxRd == w_fdRt)) ||
                      ((w_fdOp == OP_SW) && (w_dxRd == w_fdRd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    dx_en    = 1'b1;
    xm_en    = 1'b1;
    mw_en    = 1'b1;
    fd_flush = 1'b0;
    dx_flush = 1'b0;
    xm_flush = 1'b0;
    md_start = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: begin
          // Multdiv launch outranks a branch and a load-use stall.
          if (w_dxIsMd) begin
            md_start    = 1'b1;
            pc_en       = 1'b0;
            fd_en       = 1'b0;
            dx_en       = 1'b0;
            xm_flush    = 1'b1;
            w_nextState = MD_BUSY;
          end else if (branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (w_loadUse) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_ready) begin
            w_nextState = IDLE;
          end else begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_en    = 1'b0;
            xm_flush = 1'b1;
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  logic w_unused;

`ifdef HAZARD_CTRL_STALL_CNT_EN
  logic [CNT_W-1:0] r_stallCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_stallCount <= '0;
    else if (!pc_en) r_stallCount <= r_stallCount + 1'b1;
  end

  assign stall_count = r_stallCount;
  assign w_unused    = ^{insn_fd[11:0], insn_dx[21:7], insn_dx[1:0]};
`else
  assign stall_count = '0;
  assign w_unused    = ^{clk, insn_fd[11:0], insn_dx[21:7], insn_dx[1:0]};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; expected stall_count follows
// HAZARD_CTRL_STALL_CNT_EN so the same bench serves both builds.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] insn_fd, insn_dx;
  logic        branch_taken, md_ready;
  logic        pc_en, fd_en, dx_en, xm_en, mw_en;
  logic        fd_flush, dx_flush, xm_flush, md_start;
  logic [31:0] stall_count;

  int checks   = 0;
  int failures = 0;
  int expStalls = 0;

  // Output vector order: pc fd dx xm mw | fd_flush dx_flush xm_flush | md_start
  localparam logic [8:0] RUN    = 9'b11111_000_0;
  localparam logic [8:0] LDUSE  = 9'b00111_010_0;
  localparam logic [8:0] BRANCH = 9'b11111_110_0;
  localparam logic [8:0] LAUNCH = 9'b00011_001_1;
  localparam logic [8:0] BUSY   = 9'b00011_001_0;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .insn_fd(insn_fd), .insn_dx(insn_dx),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
    .md_start(md_start), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] aluop);
    return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  task automatic applyStimulus(input logic [31:0] fd, input logic [31:0] dx,
                               input logic br, input logic rdy);
    insn_fd      = fd;
    insn_dx      = dx;
    branch_taken = br;
    md_ready     = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [8:0] expected);
    logic [8:0] observed;
    observed = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush, md_start};
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic checkCount(input string tag);
    logic [31:0] expected;
`ifdef HAZARD_CTRL_STALL_CNT_EN
    expected = 32'(expStalls);
`else
    expected = 32'd0;
`endif
    checks++;
    assert (stall_count === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, stall_count, expected);
    end
  endtask

  initial begin
    logic [31:0] nop, addR, mulI, divI;
    nop  = 32'd0;
    addR = mk(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00000);
    mulI = mk(5'b00000, 5'd6, 5'd2, 5'd3, 5'b00110);
    divI = mk(5'b00000, 5'd6, 5'd2, 5'd3, 5'b00111);

    reset = 1'b1;
    applyStimulus(nop, nop, 1'b0, 1'b0);
    checkOutput("reset_outputs", RUN);
    checkCount("reset_count");
    tick();
    reset = 1'b0;

    applyStimulus(addR, mk(5'b00000, 5'd4, 5'd1, 5'd1, 5'b00000), 1'b0, 1'b0);
    checkOutput("no_hazard", RUN);
    tick();

    applyStimulus(mk(5'b00000, 5'd1, 5'd5, 5'd2, 5'b00000), mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'b0), 1'b0, 1'b0);
    checkOutput("loaduse_rs", LDUSE);
    tick(); expStalls++;
    applyStimulus(mk(5'b00000, 5'd1, 5'd5, 5'd2, 5'b00000), nop, 1'b0, 1'b0);
    checkOutput("after_loaduse", RUN);
    checkCount("count_after_loaduse");
    tick();

    applyStimulus(mk(5'b00000, 5'd1, 5'd2, 5'd7, 5'b00000), mk(5'b01000, 5'd7, 5'd1, 5'd0, 5'b0), 1'b0, 1'b0);
    checkOutput("loaduse_rt", LDUSE);
    tick(); expStalls++;

    applyStimulus(mk(5'b00101, 5'd1, 5'd2, 5'd7, 5'b00000), mk(5'b01000, 5'd7, 5'd1, 5'd0, 5'b0), 1'b0, 1'b0);
    checkOutput("itype_rt_ignored", RUN);
    tick();

    applyStimulus(mk(5'b00111, 5'd9, 5'd2, 5'd0, 5'b00000), mk(5'b01000, 5'd9, 5'd1, 5'd0, 5'b0), 1'b0, 1'b0);
    checkOutput("loaduse_sw_rd", LDUSE);
    tick(); expStalls++;

    applyStimulus(mk(5'b00000, 5'd1, 5'd0, 5'd0, 5'b00000), mk(5'b01000, 5'd0, 5'd1, 5'd0, 5'b0), 1'b0, 1'b0);
    checkOutput("lw_rd0_no_stall", RUN);
    tick();
    checkCount("count_after_loads");

    applyStimulus(mk(5'b00000, 5'd1, 5'd5, 5'd2, 5'b00000), mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'b0), 1'b1, 1'b0);
    checkOutput("branch_over_loaduse", BRANCH);
    tick();
    checkCount("count_after_branch");

    applyStimulus(addR, addR, 1'b0, 1'b1);
    checkOutput("md_ready_idle_ignored", RUN);
    tick();

    applyStimulus(addR, mulI, 1'b0, 1'b0);
    checkOutput("mul_launch", LAUNCH);
    tick(); expStalls++;
    for (int c = 1; c < 4; c++) begin
      applyStimulus(addR, mulI, (c == 2), 1'b0);
      checkOutput($sformatf("mul_busy_%0d", c), BUSY);
      tick(); expStalls++;
    end
    applyStimulus(addR, mulI, 1'b0, 1'b1);
    checkOutput("mul_done", RUN);
    tick();
    checkCount("count_after_mul");
    applyStimulus(addR, nop, 1'b0, 1'b0);
    checkOutput("after_mul_idle", RUN);
    tick();

    applyStimulus(addR, divI, 1'b0, 1'b0);
    checkOutput("div_launch", LAUNCH);
    tick(); expStalls++;
    applyStimulus(addR, divI, 1'b0, 1'b0);
    checkOutput("div_busy_1", BUSY);
    tick(); expStalls++;
    checkOutput("div_busy_2", BUSY);
    reset = 1'b1;
    expStalls = 0;
    #1;
    checkOutput("reset_in_busy", RUN);
    checkCount("reset_in_busy_count");
    tick();
    reset = 1'b0;
    #1;
    checkOutput("relaunch_after_reset", LAUNCH);
    tick(); expStalls++;
    applyStimulus(addR, divI, 1'b0, 1'b1);
    checkOutput("div_done", RUN);
    tick();
    checkCount("count_after_div");
    applyStimulus(addR, nop, 1'b0, 1'b0);
    checkOutput("final_idle", RUN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
